muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters SHALL be none; the datapath is fixed at 32 bits.
REQ-002 clock  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 a  input  32  operand A (multiplicand / dividend), sampled only when a start is accepted.
REQ-005 b  input  32  operand B (multiplier / divisor), sampled only when a start is accepted.
REQ-006 op  input  2  operation select: 00 multu, 01 mult, 10 divu, 11 div.
REQ-007 start  input  1  request to begin an operation; a single-cycle pulse is sufficient.
REQ-008 hi_we  input  1  mthi write enable.
REQ-009 lo_we  input  1  mtlo write enable.
REQ-010 wdata  input  32  data for mthi / mtlo.
REQ-011 busy  output  1  registered; high while an operation is in flight.
REQ-012 done  output  1  registered; one-cycle pulse when hi/lo take a new result.
REQ-013 div_zero  output  1  registered; sticky flag for the last divide, set if its divisor was 0.
REQ-014 hi  output  32  HI register: product[63:32] or remainder.
REQ-015 lo  output  32  LO register: product[31:0] or quotient.

Function
REQ-016 FSM states SHALL be IDLE, CALC, FIX.
- IDLE -> CALC on an accepted start.
- CALC -> FIX after 32 iterations.
- FIX -> IDLE.
REQ-017 A start SHALL be accepted only in IDLE with reset low.
- On acceptance, latch a, b and op, and clear the iteration counter.
- A start while busy is ignored, with no effect on state or outputs.
REQ-018 Latency: if start is accepted at edge N, then:
- busy is high after edges N..N+33;
- at edge N+34, hi/lo are written, done=1 for one cycle, busy=0.
REQ-019 Signed ops (mult, div) SHALL iterate on operand magnitudes and apply the sign correction in FIX.
REQ-020 Multiply algorithm:
- one shift-add step per CALC cycle;
- {hi,lo} receives the full 64-bit product, two's complement for mult.
REQ-021 Divide algorithm:
- one restoring step per CALC cycle;
- lo receives the quotient, truncated toward zero;
- hi receives the remainder, with the sign of the dividend.
REQ-022 div with a=0x80000000 and b=0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000; no trap.
REQ-023 Divide by zero (op[1]=1, b=0):
- FSM goes IDLE -> FIX -> IDLE;
- done pulses at edge N+2;
- hi and lo are unchanged;
- div_zero is set to 1.
REQ-024 Any divide with nonzero b SHALL clear div_zero when its done pulses; multiplies leave div_zero unchanged.
REQ-025 hi_we / lo_we SHALL write wdata to hi / lo only in IDLE with no start accepted in the same cycle; otherwise they are ignored.
REQ-026 hi and lo SHALL hold their values between writes; done SHALL never be high for two consecutive cycles.

Reset
REQ-027 reset=1 at an edge SHALL force the following, from any state including mid-CALC:
- state=IDLE, busy=0, done=0, div_zero=0;
- hi=0, lo=0, iteration counter=0.
REQ-028 An operation aborted by reset SHALL produce no done pulse and no hi/lo update.
REQ-029 A start or hi_we/lo_we asserted together with reset SHALL be ignored.

Verification
REQ-030 multu: a=100000000, b=2000, start pulse -> 34 cycles later hi=0x0000002E, lo=0x90EDD000, done pulse; busy high for exactly 34 cycles.
REQ-031 mult: a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-032 div: a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu: a=100000000, b=2000 -> lo=0x0000C350, hi=0.
REQ-033 Divide by zero: preload hi=0x11111111 and lo=0x22222222 via mthi/mtlo, then divu with b=0 -> done at N+2, hi and lo unchanged, div_zero=1. A following divu 10/3 -> lo=3, hi=1, div_zero=0.
REQ-034 Abort: reset at cycle 10 of a multu -> busy=0, hi=lo=0, no done pulse. A new start at the next edge completes normally.
REQ-035 Ignored requests: a second start, and hi_we, asserted mid-operation -> ignored; the result matches the first operation only.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Operand, command and result bundle between a requester and the 32-bit multiply/divide unit.
interface muldiv_unit_if;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic        start;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output a, b, op, start, hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  a, b, op, start, hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multu/mult/divu/div with HI/LO result registers and mthi/mtlo writes.
// Start accepted at edge N: result and done at edge N+34; divide by zero finishes at N+2.
module muldiv_unit (
  input  logic         clock,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [1:0]  op_q;
  logic [31:0] mcand;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic        neg_lo;
  logic        neg_hi;
  logic        by_zero;
  logic        fix_phase;
  logic        busy_q;
  logic        done_q;
  logic        div_zero_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        sign_a;
  logic        sign_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [31:0] step_hi;
  logic [31:0] step_lo;
  logic [63:0] neg_prod;

  assign sign_a   = bus.op[0] & bus.a[31];
  assign sign_b   = bus.op[0] & bus.b[31];
  assign mag_a    = sign_a ? (32'd0 - bus.a) : bus.a;
  assign mag_b    = sign_b ? (32'd0 - bus.b) : bus.b;
  assign neg_prod = 64'd0 - {acc_hi, acc_lo};

  // One iteration: multiply shifts the product right through acc_lo,
  // divide shifts the dividend left out of acc_lo into the partial remainder.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : 33'd0);
    div_shift = {acc_hi, acc_lo[31]};
    div_diff  = div_shift - {1'b0, mcand};
    step_hi   = mul_sum[32:1];
    step_lo   = {mul_sum[0], acc_lo[31:1]};
    if (op_q[1]) begin
      if (div_diff[32]) begin
        step_hi = div_shift[31:0];
        step_lo = {acc_lo[30:0], 1'b0};
      end else begin
        step_hi = div_diff[31:0];
        step_lo = {acc_lo[30:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= '0;
      mcand      <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      neg_lo     <= 1'b0;
      neg_hi     <= 1'b0;
      by_zero    <= 1'b0;
      fix_phase  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q      <= bus.op;
            mcand     <= mag_b;
            acc_hi    <= '0;
            acc_lo    <= mag_a;
            neg_lo    <= sign_a ^ sign_b;
            neg_hi    <= bus.op[1] ? sign_a : (sign_a ^ sign_b);
            by_zero   <= bus.op[1] && (bus.b == 32'd0);
            cnt       <= '0;
            fix_phase <= 1'b0;
            busy_q    <= 1'b1;
            state     <= (bus.op[1] && (bus.b == 32'd0)) ? FIX : CALC;
          end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIX;
        end
        FIX: begin
          if (!fix_phase) begin
            // First FIX cycle restores signs on the magnitude result
            fix_phase <= 1'b1;
            if (!by_zero) begin
              if (op_q[1]) begin
                if (neg_lo) acc_lo <= 32'd0 - acc_lo;
                if (neg_hi) acc_hi <= 32'd0 - acc_hi;
              end else if (neg_lo) begin
                acc_hi <= neg_prod[63:32];
                acc_lo <= neg_prod[31:0];
              end
            end
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            if (by_zero) begin
              div_zero_q <= 1'b1;
            end else begin
              hi_q <= acc_hi;
              lo_q <= acc_lo;
              if (op_q[1]) div_zero_q <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule
